inv_pipe_bank: RTL and testbench
================================

// Module: inv_pipe_bank
//
// PURPOSE
// - Parametrised, registered successor to the single-bit switch-level NOT gate.
// - WIDTH-bit datapath with four modes: pass, invert, masked invert, hold-last.
// - DEPTH-stage pipeline with valid/ready handshake and per-stage backpressure.
// - Saturating transfer counter for bench and debug visibility.
// - Sits between a producer and consumer wherever a timed, stallable inverter is needed.
//
// PARAMETERS
// - WIDTH     8           data width in bits (>=1)
// - DEPTH     3           pipeline stages (>=1); unstalled latency in cycles
// - MASK_RST  {WIDTH{1}}  reset value of the invert-mask register
// - CNT_W     16          width of xfer_cnt
//
// PORTS
// - clk        in   1       rising-edge clock
// - rst        in   1       asynchronous reset, active-high
// - in_valid   in   1       producer has a word
// - in_ready   out  1       bank accepts a word this cycle
// - in_data    in   WIDTH   input word
// - mode       in   2       00 PASS, 01 INV, 10 MASK, 11 HOLD; sampled with the word
// - mask_wr    in   1       load mask_in into the mask register
// - mask_in    in   WIDTH   new invert mask
// - out_valid  out  1       output word valid
// - out_ready  in   1       consumer accepts
// - out_data   out  WIDTH   output word
// - xfer_cnt   out  CNT_W   count of output handshakes, saturating
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - all stage valids = 0; out_valid = 0; out_data = 0; xfer_cnt = 0
//   - mask = MASK_RST; last = 0
// - Accept: in_valid && in_ready. Transform applied at entry to stage 0:
//   - PASS -> d
//   - INV  -> ~d
//   - MASK -> d ^ mask
//   - HOLD -> last; in_data is ignored
// - last updates to the transformed word on every accept. HOLD rewrites it with its own value.
// - Transfer rules:
//   - stage k loads from stage k-1 when ready_k = !valid_k || ready_{k+1}
//   - ready_DEPTH = out_ready; in_ready = ready_0, combinational
// - Stages are bubble-collapsing. Stalled stages hold both data and valid.
// - Latency: accepted at edge t -> out_valid from edge t+DEPTH-1 when unstalled.
// - Throughput: 1 word/cycle with out_ready held high.
// - out_data/out_valid remain stable while out_valid && !out_ready.
// - Mask write and accept in the same cycle: the accepted word uses the OLD mask.
// - Output handshake (out_valid && out_ready) increments xfer_cnt.
//   - It saturates at 2^CNT_W-1 and does not wrap.
// - rst mid-stream discards all in-flight words. No output handshake happens in the reset cycle.
// - mode changes never affect words already in the pipe.
//
// STRUCTURE
// - Package inv_pkg:
//   - mode_t enum {PASS=2'b00, INV=2'b01, MASK=2'b10, HOLD=2'b11}
//   - localparam CNT_W_DEF = 16
// - Sub-module inv_stage (WIDTH): one valid/data register with ready_in/ready_out.
//   - Instantiated DEPTH times via generate.
// - Top level holds the transform mux, the mask and last registers, and xfer_cnt.
//
// TESTING
// - Reset: assert rst mid-stream -> out_valid=0, xfer_cnt=0, in_ready=1 after release.
// - WIDTH=8, DEPTH=3, INV, in_data=8'h5A, out_ready=1 -> out_data=8'hA5; 3 words back-to-back.
// - MASK: mask_wr with 8'h0F in the same cycle as accepting 8'h00 under the reset mask
//   -> 8'hFF; next word 8'h00 -> 8'h0F.
// - HOLD after INV of 8'h3C -> outputs 8'hC3 repeatedly; in_data is ignored.
// - Backpressure: out_ready=0 for 5 cycles with 4 words sent.
//   - in_ready drops after DEPTH words; out_data is stable.
//   - The words drain in order with no loss or duplication.
// - Counter: CNT_W=4, 20 transfers -> xfer_cnt=4'hF, no wrap.

Source files
------------

// File: rtl/inv_pkg.sv
// inv_pkg
// Shared definitions for the inverter pipeline bank.
//   mode_t     : word transform selected at accept time
//   CNT_W_DEF  : default width of the transfer counter
package inv_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    INV  = 2'b01,
    MASK = 2'b10,
    HOLD = 2'b11
  } mode_t;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/inv_stage.sv
// inv_stage
// One register slot of the bubble-collapsing pipeline.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : upstream slot (or the accept path) holds a word
//   in_data    : upstream word
//   ready_out  : this slot can load this cycle (goes to the upstream slot)
//   ready_in   : downstream slot can load this cycle
//   out_valid  : this slot holds a word
//   out_data   : the word held by this slot
module inv_stage
  import inv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             ready_out,
  input  logic             ready_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Slot may load when empty or when its word leaves this cycle; this is
  // what lets bubbles collapse instead of travelling down the pipe.
  always_comb begin
    ready_out = !valid_q || ready_in;
  end

  // Next slot contents: load from upstream when ready, otherwise hold both
  // data and valid. Data is kept on an empty load to avoid needless toggling.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_out) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end else begin
        data_d = data_q;
      end
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/inv_pipe_bank.sv
// inv_pipe_bank
// Registered, stallable inverter bank: a transform mux (pass / invert /
// masked invert / hold-last) in front of a DEPTH-slot valid/ready pipeline,
// plus a saturating count of output handshakes.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : producer handshake (in_ready is combinational)
//   in_data, mode       : input word and its transform, sampled together
//   mask_wr, mask_in    : load a new invert mask
//   out_valid/out_ready : consumer handshake
//   out_data            : output word
//   xfer_cnt            : saturating count of output handshakes
module inv_pipe_bank
  import inv_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 3,
  parameter logic [WIDTH-1:0] MASK_RST = {WIDTH{1'b1}},
  parameter int               CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic             mask_wr,
  input  logic [WIDTH-1:0] mask_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] last_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  mode_t            mode_s;
  logic [WIDTH-1:0] word_s;
  logic             accept_s;
  logic             out_hs_s;

  assign mode_s   = mode_t'(mode);
  assign accept_s = in_valid && in_ready;
  assign out_hs_s = out_valid && out_ready;

  // Transform applied on entry to the first slot. The mask used here is the
  // registered one, so a same-cycle mask write only affects later words.
  always_comb begin
    word_s = in_data;
    case (mode_s)
      PASS:    word_s = in_data;
      INV:     word_s = ~in_data;
      MASK:    word_s = in_data ^ mask_q;
      HOLD:    word_s = last_q;
      default: word_s = in_data;
    endcase
  end

  // Mask, last-word and counter next-state. The counter sticks at all-ones.
  always_comb begin
    mask_d = mask_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (mask_wr) begin
      mask_d = mask_in;
    end else begin
      mask_d = mask_q;
    end
    if (accept_s) begin
      last_d = word_s;
    end else begin
      last_d = last_q;
    end
    if (out_hs_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Mask, last-word and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= MASK_RST;
      last_q <= {WIDTH{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      mask_q <= mask_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;

  // Pipeline slots. Each slot gets its own local handshake nets so the
  // backward ready chain runs through distinct signals rather than through
  // bits of one shared vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             v_in_s;
    logic [WIDTH-1:0] d_in_s;
    logic             rdy_in_s;
    logic             rdy_out_s;
    logic             v_out_s;
    logic [WIDTH-1:0] d_out_s;

    if (k == 0) begin : g_first
      assign v_in_s = in_valid;
      assign d_in_s = word_s;
    end else begin : g_next
      assign v_in_s = g_stage[k-1].v_out_s;
      assign d_in_s = g_stage[k-1].d_out_s;
    end

    if (k == DEPTH - 1) begin : g_last
      assign rdy_in_s = out_ready;
    end else begin : g_inner
      assign rdy_in_s = g_stage[k+1].rdy_out_s;
    end

    inv_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_in_s),
      .in_data   (d_in_s),
      .ready_out (rdy_out_s),
      .ready_in  (rdy_in_s),
      .out_valid (v_out_s),
      .out_data  (d_out_s)
    );
  end

  assign in_ready  = g_stage[0].rdy_out_s;
  assign out_valid = g_stage[DEPTH-1].v_out_s;
  assign out_data  = g_stage[DEPTH-1].d_out_s;

endmodule

// File: tb/tb_inv_pipe_bank.sv
module tb_inv_pipe_bank;
  import inv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  mode;
  logic        mask_wr;
  logic [7:0]  mask_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] xfer_cnt;

  logic        c_in_ready;
  logic        c_out_valid;
  logic [7:0]  c_out_data;
  logic [3:0]  c_xfer_cnt;

  int checks   = 0;
  int failures = 0;
  int last_wait;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  inv_pipe_bank u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .mask_wr(mask_wr), .mask_in(mask_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_cnt(xfer_cnt)
  );

  inv_pipe_bank #(.CNT_W(4)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .mode(mode), .mask_wr(mask_wr), .mask_in(mask_in),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
    .xfer_cnt(c_xfer_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one word, wait (bounded) for acceptance, queue its expected output.
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [7:0] e);
    int w;
    w = 0;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    last_wait = w;
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end else begin
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every queued word has been seen at the output.
  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: a word is transferred at the coming rising edge when valid and
  // ready are both high between edges.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {24'h0, out_data}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    mode      = PASS;
    mask_wr   = 1'b0;
    mask_in   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    chk("rst_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // INV: single word latency, then back-to-back words
    send(8'h5A, INV, 8'hA5);
    chk("lat_edge_t", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("lat_edge_t1", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("lat_edge_t2", {31'h0, out_valid}, 32'h1);
    drain();
    send(8'h5A, INV, 8'hA5);
    send(8'h5A, INV, 8'hA5);
    chk("b2b_wait", last_wait, 32'h0);
    send(8'h5A, INV, 8'hA5);
    chk("b2b_wait", last_wait, 32'h0);
    send(8'h12, INV, 8'hED);
    drain();
    chk("xfer_after_inv", {16'h0, xfer_cnt}, 32'd5);

    // MASK: same-cycle mask write uses the reset mask, next word the new one
    mask_wr = 1'b1;
    mask_in = 8'h0F;
    send(8'h00, MASK, 8'hFF);
    mask_wr = 1'b0;
    send(8'h00, MASK, 8'h0F);
    drain();

    // HOLD repeats the last transformed word; in_data is ignored
    send(8'h3C, INV,  8'hC3);
    send(8'h77, HOLD, 8'hC3);
    send(8'h11, HOLD, 8'hC3);
    send(8'h96, PASS, 8'h96);
    send(8'h00, HOLD, 8'h96);
    drain();

    // Backpressure: 5 stalled cycles, 4 words sent
    out_ready = 1'b0;
    send(8'h01, PASS, 8'h01);
    send(8'h02, PASS, 8'h02);
    send(8'h03, PASS, 8'h03);
    chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_out_data", {24'h0, out_data}, 32'h01);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_hold_data", {24'h0, out_data}, 32'h01);
      chk("bp_hold_ready", {31'h0, in_ready}, 32'h0);
    end
    out_ready = 1'b1;
    send(8'h04, PASS, 8'h04);
    drain();
    chk("xfer_after_bp", {16'h0, xfer_cnt}, 32'd16);

    // Reset mid-stream discards in-flight words
    out_ready = 1'b0;
    send(8'hAA, PASS, 8'hAA);
    send(8'hBB, PASS, 8'hBB);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_out_data", {24'h0, out_data}, 32'h0);
    chk("mid_rst_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
    chk("mid_rst_c_xfer_cnt", {28'h0, c_xfer_cnt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", {31'h0, out_valid}, 32'h0);

    // last and mask return to their reset values
    send(8'h55, HOLD, 8'h00);
    send(8'h00, MASK, 8'hFF);
    drain();

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      send(8'(i), PASS, 8'(i));
    end
    drain();
    chk("cnt4_saturate", {28'h0, c_xfer_cnt}, 32'hF);
    chk("cnt16_count", {16'h0, xfer_cnt}, 32'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
